// File: rtl/ddr_rw_sched.sv
// Write/read burst scheduler between a staging write FIFO and a MIG-style DDR
// controller. DDR is used as a circular buffer of 2^PTR_W bursts.
module ddr_rw_sched #(
  parameter int PTR_W       = 8,
  parameter int BURST_WORDS = 4,
  parameter int ADDR_LSB    = 2,
  parameter int MAX_WR_RUN  = 4
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             phy_init_done,
  input  logic             app_af_afull,
  input  logic             app_wdf_afull,
  input  logic             wr_req,
  input  logic             rd_req,
  output logic             wr_fifo_rd,
  output logic             app_wdf_wren,
  output logic             app_af_wren,
  output logic [2:0]       app_af_cmd,
  output logic [30:0]      app_af_addr,
  output logic [PTR_W:0]   burst_level,
  output logic             ddr_full,
  output logic             ddr_empty
);

  localparam int BEAT_W = $clog2(BURST_WORDS + 1);
  localparam int RUN_W  = $clog2(MAX_WR_RUN + 1);
  localparam int LVL_W  = PTR_W + 1;

  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(BURST_WORDS);
  localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(MAX_WR_RUN);
  localparam logic [LVL_W-1:0]  LVL_MAX  = LVL_W'(1) << PTR_W;
  localparam logic [2:0]        CMD_WR   = 3'b000;
  localparam logic [2:0]        CMD_RD   = 3'b001;

  typedef enum logic [2:0] {
    INIT    = 3'd0,
    ARB     = 3'd1,
    WR_DATA = 3'd2,
    WR_CMD  = 3'd3,
    RD_CMD  = 3'd4,
    GAP     = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic                pop_q, pop_d;
  logic                wdf_wren_q, wdf_wren_d;
  logic                af_wren_q, af_wren_d;
  logic [2:0]          cmd_q, cmd_d;
  logic [30:0]         addr_q, addr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [RUN_W-1:0]    run_q, run_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic                full_q, full_d;
  logic                empty_q, empty_d;
  logic                wr_elig_s;
  logic                rd_elig_s;

  function automatic logic [30:0] mk_addr(input logic [PTR_W-1:0] ptr);
    mk_addr = 31'(ptr) << ADDR_LSB;
  endfunction

  assign wr_elig_s = wr_req & ~full_q & ~app_wdf_afull & ~app_af_afull;
  assign rd_elig_s = rd_req & ~empty_q & ~app_af_afull;

  always_comb begin
    state_d    = state_q;
    pop_d      = 1'b0;
    wdf_wren_d = pop_q;
    af_wren_d  = 1'b0;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    beat_d     = beat_q;
    run_d      = run_q;
    level_d    = level_q;

    case (state_q)
      INIT: begin
        if (phy_init_done) begin
          state_d = ARB;
        end else begin
          state_d = INIT;
        end
      end
      // Writes win unless a read is waiting and the write run is exhausted.
      ARB: begin
        if (wr_elig_s && (!rd_elig_s || (run_q < RUN_MAX))) begin
          state_d = WR_DATA;
          pop_d   = 1'b1;
          beat_d  = BEAT_W'(1);
        end else if (rd_elig_s) begin
          state_d = RD_CMD;
        end else begin
          state_d = ARB;
        end
      end
      WR_DATA: begin
        if (beat_q == BEAT_MAX) begin
          state_d = WR_CMD;
        end else if (!app_wdf_afull) begin
          pop_d  = 1'b1;
          beat_d = beat_q + BEAT_W'(1);
        end else begin
          pop_d  = 1'b0;
        end
      end
      WR_CMD: begin
        if (!app_af_afull) begin
          af_wren_d = 1'b1;
          cmd_d     = CMD_WR;
          addr_d    = mk_addr(wr_ptr_q);
          wr_ptr_d  = wr_ptr_q + PTR_W'(1);
          level_d   = level_q + LVL_W'(1);
          run_d     = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
          beat_d    = BEAT_W'(0);
          state_d   = GAP;
        end else begin
          state_d   = WR_CMD;
        end
      end
      RD_CMD: begin
        if (!app_af_afull) begin
          af_wren_d = 1'b1;
          cmd_d     = CMD_RD;
          addr_d    = mk_addr(rd_ptr_q);
          rd_ptr_d  = rd_ptr_q + PTR_W'(1);
          level_d   = level_q - LVL_W'(1);
          run_d     = RUN_W'(0);
          state_d   = GAP;
        end else begin
          state_d   = RD_CMD;
        end
      end
      GAP: begin
        state_d = ARB;
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  assign full_d  = (level_d == LVL_MAX);
  assign empty_d = (level_d == LVL_W'(0));

  // State and registered outputs.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q    <= INIT;
      pop_q      <= 1'b0;
      wdf_wren_q <= 1'b0;
      af_wren_q  <= 1'b0;
      cmd_q      <= 3'b000;
      addr_q     <= 31'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      beat_q     <= '0;
      run_q      <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      pop_q      <= pop_d;
      wdf_wren_q <= wdf_wren_d;
      af_wren_q  <= af_wren_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      beat_q     <= beat_d;
      run_q      <= run_d;
      level_q    <= level_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
    end
  end

  assign wr_fifo_rd   = pop_q;
  assign app_wdf_wren = wdf_wren_q;
  assign app_af_wren  = af_wren_q;
  assign app_af_cmd   = cmd_q;
  assign app_af_addr  = addr_q;
  assign burst_level  = level_q;
  assign ddr_full     = full_q;
  assign ddr_empty    = empty_q;

endmodule

// File: tb/tb_ddr_rw_sched.sv
// Directed testbench for ddr_rw_sched with default parameters.
module tb_ddr_rw_sched;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic        phy_init_done;
  logic        app_af_afull;
  logic        app_wdf_afull;
  logic        wr_req;
  logic        rd_req;
  logic        wr_fifo_rd;
  logic        app_wdf_wren;
  logic        app_af_wren;
  logic [2:0]  app_af_cmd;
  logic [30:0] app_af_addr;
  logic [8:0]  burst_level;
  logic        ddr_full;
  logic        ddr_empty;

  int total = 0;
  int bad   = 0;

  ddr_rw_sched dut (
    .sys_clk       (sys_clk),
    .reset         (reset),
    .phy_init_done (phy_init_done),
    .app_af_afull  (app_af_afull),
    .app_wdf_afull (app_wdf_afull),
    .wr_req        (wr_req),
    .rd_req        (rd_req),
    .wr_fifo_rd    (wr_fifo_rd),
    .app_wdf_wren  (app_wdf_wren),
    .app_af_wren   (app_af_wren),
    .app_af_cmd    (app_af_cmd),
    .app_af_addr   (app_af_addr),
    .burst_level   (burst_level),
    .ddr_full      (ddr_full),
    .ddr_empty     (ddr_empty)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Reset, then release with calibration done so the DUT sits in ARB.
  task automatic do_reset_init();
    reset = 1'b1; phy_init_done = 1'b0; app_af_afull = 1'b0;
    app_wdf_afull = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    tick(); tick();
    reset = 1'b0; phy_init_done = 1'b1;
    tick();
  endtask

  task automatic wait_cmd(input int budget, output bit got,
                          output logic [2:0] c, output logic [30:0] a);
    got = 1'b0; c = 3'b111; a = 31'd0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (app_af_wren) begin
        got = 1'b1; c = app_af_cmd; a = app_af_addr;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; phy_init_done = 1'b0; app_af_afull = 1'b0;
    app_wdf_afull = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    tick(); tick();
    total++;
    if ({wr_fifo_rd, app_wdf_wren, app_af_wren, ddr_full, ddr_empty} !== 5'b00001) begin
      bad++; $display("FAIL reset_flags: got %b expected 00001",
                      {wr_fifo_rd, app_wdf_wren, app_af_wren, ddr_full, ddr_empty});
    end
    total++;
    if (burst_level !== 9'd0 || app_af_cmd !== 3'd0 || app_af_addr !== 31'd0) begin
      bad++; $display("FAIL reset_regs: got lvl=%0d cmd=%0d addr=%0h expected 0/0/0",
                      burst_level, app_af_cmd, app_af_addr);
    end
  endtask

  task automatic test_init();
    int act;
    int lat;
    bit got;
    logic [2:0]  c;
    logic [30:0] a;
    reset = 1'b1; tick(); reset = 1'b0;
    wr_req = 1'b1; phy_init_done = 1'b0;
    act = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (wr_fifo_rd || app_af_wren) act++;
    end
    total++;
    if (act !== 0) begin
      bad++; $display("FAIL init_idle: got %0d active cycles expected 0", act);
    end
    phy_init_done = 1'b1;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      tick(); lat++;
      if (wr_fifo_rd) break;
    end
    total++;
    if (lat !== 2) begin
      bad++; $display("FAIL init_latency: got %0d expected 2", lat);
    end
    wr_req = 1'b0; phy_init_done = 1'b0;
    wait_cmd(20, got, c, a);
    total++;
    if (!got || c !== 3'b000 || a !== 31'd0) begin
      bad++; $display("FAIL init_first_cmd: got seen=%0d cmd=%0d addr=%0h expected 1/0/0", got, c, a);
    end
  endtask

  task automatic test_single_write();
    logic [15:0] pop_m, wdf_m, af_m;
    logic [2:0]  c;
    logic [30:0] a;
    do_reset_init();
    pop_m = 16'h0; wdf_m = 16'h0; af_m = 16'h0; c = 3'b111; a = 31'h7fff_ffff;
    wr_req = 1'b1;
    for (int cy = 1; cy <= 12; cy++) begin
      tick();
      if (wr_fifo_rd)   pop_m[cy] = 1'b1;
      if (app_wdf_wren) wdf_m[cy] = 1'b1;
      if (app_af_wren) begin af_m[cy] = 1'b1; c = app_af_cmd; a = app_af_addr; end
      if (cy == 1) wr_req = 1'b0;
    end
    total++;
    if (pop_m !== 16'h001E) begin
      bad++; $display("FAIL single_pops: got %h expected 001e", pop_m);
    end
    total++;
    if (wdf_m !== 16'h003C) begin
      bad++; $display("FAIL single_wdf_wren: got %h expected 003c", wdf_m);
    end
    total++;
    if (af_m !== 16'h0040 || c !== 3'b000 || a !== 31'd0) begin
      bad++; $display("FAIL single_cmd: got mask=%h cmd=%0d addr=%0h expected 0040/0/0", af_m, c, a);
    end
    total++;
    if (burst_level !== 9'd1 || ddr_empty !== 1'b0) begin
      bad++; $display("FAIL single_level: got lvl=%0d empty=%0d expected 1/0", burst_level, ddr_empty);
    end
  endtask

  task automatic test_wdf_pause();
    logic [15:0] pop_m, wdf_m, af_m;
    do_reset_init();
    pop_m = 16'h0; wdf_m = 16'h0; af_m = 16'h0;
    wr_req = 1'b1;
    for (int cy = 1; cy <= 14; cy++) begin
      tick();
      if (wr_fifo_rd)   pop_m[cy] = 1'b1;
      if (app_wdf_wren) wdf_m[cy] = 1'b1;
      if (app_af_wren)  af_m[cy]  = 1'b1;
      if (cy == 1) wr_req = 1'b0;
      if (cy == 2) app_wdf_afull = 1'b1;
      if (cy == 5) app_wdf_afull = 1'b0;
    end
    total++;
    if (pop_m !== 16'h00C6) begin
      bad++; $display("FAIL pause_pops: got %h expected 00c6", pop_m);
    end
    total++;
    if (wdf_m !== 16'h018C) begin
      bad++; $display("FAIL pause_wdf_wren: got %h expected 018c", wdf_m);
    end
    total++;
    if (af_m !== 16'h0200) begin
      bad++; $display("FAIL pause_cmd: got %h expected 0200", af_m);
    end
  endtask

  task automatic test_arbitration();
    logic [2:0]  exp_c [10] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1};
    logic [30:0] exp_a [10] = '{31'd0, 31'd4, 31'd8, 31'd12, 31'd0,
                                31'd16, 31'd20, 31'd24, 31'd28, 31'd4};
    int  n;
    bit  prev;
    do_reset_init();
    wr_req = 1'b1; rd_req = 1'b1;
    n = 0; prev = 1'b0;
    for (int cy = 0; cy < 400 && n < 10; cy++) begin
      tick();
      if (app_af_wren) begin
        total++;
        if (prev) begin
          bad++; $display("FAIL arb_gap: got back-to-back commands at #%0d expected idle cycle", n);
        end
        total++;
        if (app_af_cmd !== exp_c[n] || app_af_addr !== exp_a[n]) begin
          bad++; $display("FAIL arb_cmd%0d: got cmd=%0d addr=%0h expected cmd=%0d addr=%0h",
                          n, app_af_cmd, app_af_addr, exp_c[n], exp_a[n]);
        end
        n++;
      end
      prev = app_af_wren;
    end
    wr_req = 1'b0; rd_req = 1'b0;
    total++;
    if (n !== 10) begin
      bad++; $display("FAIL arb_count: got %0d commands expected 10", n);
    end
    total++;
    if (burst_level !== 9'd6) begin
      bad++; $display("FAIL arb_level: got %0d expected 6", burst_level);
    end
  endtask

  task automatic test_fill_drain();
    int          nwr;
    int          nrd;
    int          pops;
    logic [30:0] last_a;
    bit          got;
    logic [2:0]  c;
    logic [30:0] a;
    do_reset_init();
    wr_req = 1'b1;
    nwr = 0; last_a = 31'h7fff_ffff;
    for (int cy = 0; cy < 3000 && nwr < 256; cy++) begin
      tick();
      if (app_af_wren) begin nwr++; last_a = app_af_addr; end
    end
    total++;
    if (nwr !== 256 || last_a !== 31'd1020) begin
      bad++; $display("FAIL fill_count: got %0d last=%0h expected 256/3fc", nwr, last_a);
    end
    total++;
    if (ddr_full !== 1'b1 || burst_level !== 9'd256) begin
      bad++; $display("FAIL fill_full: got full=%0d lvl=%0d expected 1/256", ddr_full, burst_level);
    end
    pops = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (wr_fifo_rd || app_af_wren) pops++;
    end
    total++;
    if (pops !== 0) begin
      bad++; $display("FAIL full_blocks: got %0d active cycles expected 0", pops);
    end
    rd_req = 1'b1;
    wait_cmd(20, got, c, a);
    total++;
    if (!got || c !== 3'b001 || a !== 31'd0) begin
      bad++; $display("FAIL full_read: got seen=%0d cmd=%0d addr=%0h expected 1/1/0", got, c, a);
    end
    wait_cmd(30, got, c, a);
    total++;
    if (!got || c !== 3'b000 || a !== 31'd0) begin
      bad++; $display("FAIL wrap_write: got seen=%0d cmd=%0d addr=%0h expected 1/0/0", got, c, a);
    end
    wr_req = 1'b0;
    nrd = 0; last_a = 31'h7fff_ffff;
    for (int cy = 0; cy < 2000; cy++) begin
      tick();
      if (app_af_wren) begin
        if (app_af_cmd == 3'b001) nrd++;
        last_a = app_af_addr;
      end
      if (ddr_empty) break;
    end
    total++;
    if (nrd !== 256 || last_a !== 31'd0 || burst_level !== 9'd0) begin
      bad++; $display("FAIL drain: got reads=%0d last=%0h lvl=%0d expected 256/0/0", nrd, last_a, burst_level);
    end
    pops = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (app_af_wren) pops++;
    end
    total++;
    if (pops !== 0) begin
      bad++; $display("FAIL empty_blocks: got %0d reads expected 0", pops);
    end
    rd_req = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    int          act;
    bit          got;
    logic [2:0]  c;
    logic [30:0] a;
    do_reset_init();
    wr_req = 1'b1;
    tick(); tick();
    reset = 1'b1;
    tick();
    total++;
    if ({wr_fifo_rd, app_wdf_wren, app_af_wren, ddr_empty} !== 4'b0001 || burst_level !== 9'd0) begin
      bad++; $display("FAIL midreset_outs: got %b lvl=%0d expected 0001/0",
                      {wr_fifo_rd, app_wdf_wren, app_af_wren, ddr_empty}, burst_level);
    end
    act = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (wr_fifo_rd || app_wdf_wren || app_af_wren) act++;
    end
    total++;
    if (act !== 0) begin
      bad++; $display("FAIL midreset_hold: got %0d active cycles expected 0", act);
    end
    reset = 1'b0;
    wait_cmd(30, got, c, a);
    wr_req = 1'b0;
    total++;
    if (!got || c !== 3'b000 || a !== 31'd0) begin
      bad++; $display("FAIL midreset_next: got seen=%0d cmd=%0d addr=%0h expected 1/0/0", got, c, a);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_single_write();
    test_wdf_pause();
    test_arbitration();
    test_fill_drain();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
